// File: rtl/pong_pkg.sv
// Shared encodings and constants for the Pong datapath: command selects,
// register widths, centre positions and the internal axis-register opcodes.
package pong_pkg;

   localparam int COORD_W = 10;
   localparam int SCORE_W = 4;
   localparam int CMP_W   = COORD_W + 1;

   localparam logic [COORD_W-1:0] BALL_X_CENTRE = 10'd316;
   localparam logic [COORD_W-1:0] BALL_Y_CENTRE = 10'd236;
   localparam logic [COORD_W-1:0] PAD_CENTRE    = 10'd208;

   // SIGN1 drives the direction flag to 1 (right for x, up for y).
   localparam logic [1:0] BALL_SEL_CENTRE = 2'd0;
   localparam logic [1:0] BALL_SEL_SIGN1  = 2'd1;
   localparam logic [1:0] BALL_SEL_SIGN0  = 2'd2;
   localparam logic [1:0] BALL_SEL_HOLD   = 2'd3;

   localparam logic [2:0] PAD_SEL_CENTRE = 3'd0;
   localparam logic [2:0] PAD_SEL_UP     = 3'd1;
   localparam logic [2:0] PAD_SEL_DOWN   = 3'd2;
   localparam logic [2:0] PAD_SEL_TOP    = 3'd3;
   localparam logic [2:0] PAD_SEL_BOTTOM = 3'd4;

   typedef enum logic [2:0] {
      AX_HOLD = 3'd0,
      AX_LOAD = 3'd1,
      AX_INC  = 3'd2,
      AX_DEC  = 3'd3,
      AX_MIN  = 3'd4,
      AX_MAX  = 3'd5
   } axis_op_e;

endpackage

// File: rtl/pong_axis_reg.sv
// One coordinate register: load centre, step up/down with saturation, or
// clamp to either end of its range. Reset loads the centre.
module pong_axis_reg
   import pong_pkg::*;
#(
   parameter int             W      = COORD_W,
   parameter logic [W-1:0]   CENTRE = '0,
   parameter logic [W-1:0]   STEP   = 1,
   parameter logic [W-1:0]   HI     = '1,
   parameter bit             SAT_HI = 1'b1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         en,
   input  logic [2:0]   op,
   output logic [W-1:0] q
);

   function automatic logic [W-1:0] sat_add(input logic [W-1:0] a);
      logic [W:0] s;
      s = {1'b0, a} + {1'b0, STEP};
      if (SAT_HI && (s > {1'b0, HI}))
         return HI;
      return s[W-1:0];
   endfunction

   function automatic logic [W-1:0] sat_sub(input logic [W-1:0] a);
      if (a < STEP)
         return '0;
      return a - STEP;
   endfunction

   logic [W-1:0] q_nxt;

   always_comb begin
      q_nxt = q;
      case (op)
         AX_LOAD: q_nxt = CENTRE;
         AX_INC:  q_nxt = sat_add(q);
         AX_DEC:  q_nxt = sat_sub(q);
         AX_MIN:  q_nxt = '0;
         AX_MAX:  q_nxt = HI;
         default: q_nxt = q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset)
         q <= CENTRE;
      else if (en)
         q <= q_nxt;
   end

endmodule

// File: rtl/pong_datapath.sv
// Pong register/compare datapath: applies controller commands to ball, paddle
// and score registers and derives the status flags the controller branches on.
module pong_datapath
   import pong_pkg::*;
#(
   parameter int SCREEN_W    = 640,
   parameter int SCREEN_H    = 480,
   parameter int BALL_SIZE   = 8,
   parameter int PADDLE_W    = 8,
   parameter int PADDLE_H    = 64,
   parameter int PLAYER_X    = 16,
   parameter int AI_X        = 616,
   parameter int BALL_STEP   = 2,
   parameter int PADDLE_STEP = 4,
   parameter int WIN_SCORE   = 7,
   parameter int AI_DEADBAND = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [1:0]           sel_x_ball,
   input  logic                 en_x_ball,
   input  logic [1:0]           sel_y_ball,
   input  logic                 en_y_ball,
   input  logic [2:0]           sel_y_paddle,
   input  logic                 en_y_paddle,
   input  logic [2:0]           sel_y_ai,
   input  logic                 en_y_ai,
   input  logic                 sel_player_score,
   input  logic                 en_player_score,
   input  logic                 sel_ai_score,
   input  logic                 en_ai_score,
   output logic                 x_sign,
   output logic                 y_sign,
   output logic                 ball_too_high,
   output logic                 ball_too_low,
   output logic                 paddle_too_high,
   output logic                 paddle_too_low,
   output logic                 ai_too_high,
   output logic                 ai_too_low,
   output logic                 ai_up,
   output logic                 ai_down,
   output logic                 player_collision,
   output logic                 ai_collision,
   output logic                 player_scored,
   output logic                 ai_scored,
   output logic                 game_over,
   output logic [COORD_W-1:0]   ball_x,
   output logic [COORD_W-1:0]   ball_y,
   output logic [COORD_W-1:0]   paddle_y,
   output logic [COORD_W-1:0]   ai_y,
   output logic [SCORE_W-1:0]   player_score,
   output logic [SCORE_W-1:0]   ai_score
);

   localparam logic [CMP_W-1:0] C_SCREEN_W  = CMP_W'(SCREEN_W);
   localparam logic [CMP_W-1:0] C_SCREEN_H  = CMP_W'(SCREEN_H);
   localparam logic [CMP_W-1:0] C_BALL_SIZE = CMP_W'(BALL_SIZE);
   localparam logic [CMP_W-1:0] C_BALL_HALF = CMP_W'(BALL_SIZE / 2);
   localparam logic [CMP_W-1:0] C_PAD_W     = CMP_W'(PADDLE_W);
   localparam logic [CMP_W-1:0] C_PAD_H     = CMP_W'(PADDLE_H);
   localparam logic [CMP_W-1:0] C_PAD_HALF  = CMP_W'(PADDLE_H / 2);
   localparam logic [CMP_W-1:0] C_PLAYER_X  = CMP_W'(PLAYER_X);
   localparam logic [CMP_W-1:0] C_AI_X      = CMP_W'(AI_X);
   localparam logic [CMP_W-1:0] C_BSTEP     = CMP_W'(BALL_STEP);
   localparam logic [CMP_W-1:0] C_PSTEP     = CMP_W'(PADDLE_STEP);
   localparam logic [CMP_W-1:0] C_WIN       = CMP_W'(WIN_SCORE);
   localparam logic [CMP_W-1:0] C_DEADBAND  = CMP_W'(AI_DEADBAND);

   localparam logic [COORD_W-1:0] BALL_Y_MAX = COORD_W'(SCREEN_H - BALL_SIZE);
   localparam logic [COORD_W-1:0] PAD_Y_MAX  = COORD_W'(SCREEN_H - PADDLE_H);

   // sign1_inc: whether the "direction flag := 1" select moves the coordinate up.
   function automatic axis_op_e ball_op(input logic [1:0] sel, input logic sign1_inc);
      case (sel)
         BALL_SEL_CENTRE: return AX_LOAD;
         BALL_SEL_SIGN1:  return sign1_inc ? AX_INC : AX_DEC;
         BALL_SEL_SIGN0:  return sign1_inc ? AX_DEC : AX_INC;
         BALL_SEL_HOLD:   return AX_HOLD;
         default:         return AX_HOLD;
      endcase
   endfunction

   function automatic axis_op_e pad_op(input logic [2:0] sel);
      case (sel)
         PAD_SEL_CENTRE: return AX_LOAD;
         PAD_SEL_UP:     return AX_DEC;
         PAD_SEL_DOWN:   return AX_INC;
         PAD_SEL_TOP:    return AX_MIN;
         PAD_SEL_BOTTOM: return AX_MAX;
         default:        return AX_HOLD;
      endcase
   endfunction

   function automatic logic [SCORE_W-1:0] sat_inc_score(input logic [SCORE_W-1:0] s);
      if (s == '1)
         return s;
      return s + SCORE_W'(1);
   endfunction

   pong_axis_reg #(
      .W(COORD_W), .CENTRE(BALL_X_CENTRE), .STEP(COORD_W'(BALL_STEP)),
      .HI('1), .SAT_HI(1'b0)
   ) u_ball_x (
      .clk(clk), .reset(reset), .en(en_x_ball),
      .op(ball_op(sel_x_ball, 1'b1)), .q(ball_x)
   );

   pong_axis_reg #(
      .W(COORD_W), .CENTRE(BALL_Y_CENTRE), .STEP(COORD_W'(BALL_STEP)),
      .HI(BALL_Y_MAX), .SAT_HI(1'b1)
   ) u_ball_y (
      .clk(clk), .reset(reset), .en(en_y_ball),
      .op(ball_op(sel_y_ball, 1'b0)), .q(ball_y)
   );

   pong_axis_reg #(
      .W(COORD_W), .CENTRE(PAD_CENTRE), .STEP(COORD_W'(PADDLE_STEP)),
      .HI(PAD_Y_MAX), .SAT_HI(1'b1)
   ) u_paddle (
      .clk(clk), .reset(reset), .en(en_y_paddle),
      .op(pad_op(sel_y_paddle)), .q(paddle_y)
   );

   pong_axis_reg #(
      .W(COORD_W), .CENTRE(PAD_CENTRE), .STEP(COORD_W'(PADDLE_STEP)),
      .HI(PAD_Y_MAX), .SAT_HI(1'b1)
   ) u_ai (
      .clk(clk), .reset(reset), .en(en_y_ai),
      .op(pad_op(sel_y_ai)), .q(ai_y)
   );

   // Serve alternates direction: each centre load flips x_sign.
   always_ff @(posedge clk) begin
      if (reset) begin
         x_sign       <= 1'b1;
         y_sign       <= 1'b0;
         player_score <= '0;
         ai_score     <= '0;
      end else begin
         if (en_x_ball) begin
            case (sel_x_ball)
               BALL_SEL_CENTRE: x_sign <= ~x_sign;
               BALL_SEL_SIGN1:  x_sign <= 1'b1;
               BALL_SEL_SIGN0:  x_sign <= 1'b0;
               default:         x_sign <= x_sign;
            endcase
         end
         if (en_y_ball) begin
            case (sel_y_ball)
               BALL_SEL_SIGN1: y_sign <= 1'b1;
               BALL_SEL_SIGN0: y_sign <= 1'b0;
               default:        y_sign <= y_sign;
            endcase
         end
         if (en_player_score)
            player_score <= sel_player_score ? sat_inc_score(player_score) : '0;
         if (en_ai_score)
            ai_score <= sel_ai_score ? sat_inc_score(ai_score) : '0;
      end
   end

   logic [CMP_W-1:0] bx, by, py, ay, ball_c, ai_c;
   logic             player_ov, ai_ov;

   assign bx     = {1'b0, ball_x};
   assign by     = {1'b0, ball_y};
   assign py     = {1'b0, paddle_y};
   assign ay     = {1'b0, ai_y};
   assign ball_c = by + C_BALL_HALF;
   assign ai_c   = ay + C_PAD_HALF;

   assign ball_too_high   = by < C_BSTEP;
   assign ball_too_low    = (by + C_BALL_SIZE + C_BSTEP) > C_SCREEN_H;
   assign paddle_too_high = py < C_PSTEP;
   assign paddle_too_low  = (py + C_PAD_H + C_PSTEP) > C_SCREEN_H;
   assign ai_too_high     = ay < C_PSTEP;
   assign ai_too_low      = (ay + C_PAD_H + C_PSTEP) > C_SCREEN_H;

   assign player_ov = ((by + C_BALL_SIZE) > py) && (by < (py + C_PAD_H));
   assign ai_ov     = ((by + C_BALL_SIZE) > ay) && (by < (ay + C_PAD_H));

   assign player_collision = player_ov && !x_sign &&
                             (bx <= (C_PLAYER_X + C_PAD_W)) &&
                             ((bx + C_BALL_SIZE) > C_PLAYER_X);
   assign ai_collision     = ai_ov && x_sign &&
                             ((bx + C_BALL_SIZE) >= C_AI_X) &&
                             (bx < (C_AI_X + C_PAD_W));

   // A paddle hit on the same cycle as the edge condition suppresses the point.
   assign ai_scored     = (bx < C_BSTEP) && !player_collision;
   assign player_scored = ((bx + C_BALL_SIZE + C_BSTEP) > C_SCREEN_W) && !ai_collision;

   assign game_over = (CMP_W'(player_score) >= C_WIN) || (CMP_W'(ai_score) >= C_WIN);

   assign ai_up   = (ball_c + C_DEADBAND) < ai_c;
   assign ai_down = ball_c > (ai_c + C_DEADBAND);

endmodule

// File: tb/tb_pong_datapath.sv
// Directed bench for pong_datapath: each task drives commands and compares
// registers and flags against hand-computed values.
module tb_pong_datapath;

   logic       clk;
   logic       reset;
   logic [1:0] sel_x_ball, sel_y_ball;
   logic       en_x_ball, en_y_ball;
   logic [2:0] sel_y_paddle, sel_y_ai;
   logic       en_y_paddle, en_y_ai;
   logic       sel_player_score, en_player_score, sel_ai_score, en_ai_score;
   logic       x_sign, y_sign, ball_too_high, ball_too_low;
   logic       paddle_too_high, paddle_too_low, ai_too_high, ai_too_low;
   logic       ai_up, ai_down, player_collision, ai_collision;
   logic       player_scored, ai_scored, game_over;
   logic [9:0] ball_x, ball_y, paddle_y, ai_y;
   logic [3:0] player_score, ai_score;

   int checks = 0;
   int errors = 0;

   pong_datapath dut (
      .clk(clk), .reset(reset),
      .sel_x_ball(sel_x_ball), .en_x_ball(en_x_ball),
      .sel_y_ball(sel_y_ball), .en_y_ball(en_y_ball),
      .sel_y_paddle(sel_y_paddle), .en_y_paddle(en_y_paddle),
      .sel_y_ai(sel_y_ai), .en_y_ai(en_y_ai),
      .sel_player_score(sel_player_score), .en_player_score(en_player_score),
      .sel_ai_score(sel_ai_score), .en_ai_score(en_ai_score),
      .x_sign(x_sign), .y_sign(y_sign),
      .ball_too_high(ball_too_high), .ball_too_low(ball_too_low),
      .paddle_too_high(paddle_too_high), .paddle_too_low(paddle_too_low),
      .ai_too_high(ai_too_high), .ai_too_low(ai_too_low),
      .ai_up(ai_up), .ai_down(ai_down),
      .player_collision(player_collision), .ai_collision(ai_collision),
      .player_scored(player_scored), .ai_scored(ai_scored), .game_over(game_over),
      .ball_x(ball_x), .ball_y(ball_y), .paddle_y(paddle_y), .ai_y(ai_y),
      .player_score(player_score), .ai_score(ai_score)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_cmds();
      en_x_ball = 0; en_y_ball = 0; en_y_paddle = 0; en_y_ai = 0;
      en_player_score = 0; en_ai_score = 0;
      sel_x_ball = 2'd3; sel_y_ball = 2'd3; sel_y_paddle = 3'd5; sel_y_ai = 3'd5;
      sel_player_score = 0; sel_ai_score = 0;
   endtask

   task automatic do_reset();
      idle_cmds();
      reset = 1;
      tick();
      reset = 0;
   endtask

   task automatic step_x(input logic [1:0] sel, input int n);
      sel_x_ball = sel; en_x_ball = 1;
      repeat (n) tick();
      en_x_ball = 0; sel_x_ball = 2'd3;
   endtask

   task automatic step_y(input logic [1:0] sel, input int n);
      sel_y_ball = sel; en_y_ball = 1;
      repeat (n) tick();
      en_y_ball = 0; sel_y_ball = 2'd3;
   endtask

   task automatic step_pad(input logic [2:0] sel, input int n);
      sel_y_paddle = sel; en_y_paddle = 1;
      repeat (n) tick();
      en_y_paddle = 0; sel_y_paddle = 3'd5;
   endtask

   task automatic step_ai(input logic [2:0] sel, input int n);
      sel_y_ai = sel; en_y_ai = 1;
      repeat (n) tick();
      en_y_ai = 0; sel_y_ai = 3'd5;
   endtask

   task automatic test_reset();
      logic [12:0] flags;
      reset = 1;
      idle_cmds();
      tick();
      reset = 0;
      tick();
      flags = {ball_too_high, ball_too_low, paddle_too_high, paddle_too_low,
               ai_too_high, ai_too_low, ai_up, ai_down, player_collision,
               ai_collision, player_scored, ai_scored, game_over};
      checks++; if (ball_x !== 10'd316) begin errors++; $display("FAIL rst_ball_x got %0d expected 316", ball_x); end
      checks++; if (ball_y !== 10'd236) begin errors++; $display("FAIL rst_ball_y got %0d expected 236", ball_y); end
      checks++; if (paddle_y !== 10'd208) begin errors++; $display("FAIL rst_paddle_y got %0d expected 208", paddle_y); end
      checks++; if (ai_y !== 10'd208) begin errors++; $display("FAIL rst_ai_y got %0d expected 208", ai_y); end
      checks++; if ({player_score, ai_score} !== 8'h00) begin errors++; $display("FAIL rst_scores got %0d/%0d expected 0/0", player_score, ai_score); end
      checks++; if ({x_sign, y_sign} !== 2'b10) begin errors++; $display("FAIL rst_signs got %b%b expected 10", x_sign, y_sign); end
      checks++; if (flags !== 13'b0) begin errors++; $display("FAIL rst_flags got %b expected all 0", flags); end
      // serve from reset flips direction to left
      step_x(2'd0, 1);
      checks++; if ({ball_x, x_sign} !== {10'd316, 1'b0}) begin errors++; $display("FAIL serve got x=%0d sign=%b expected 316/0", ball_x, x_sign); end
      step_x(2'd0, 1);
      checks++; if (x_sign !== 1'b1) begin errors++; $display("FAIL serve2_sign got %b expected 1", x_sign); end
   endtask

   task automatic test_walls();
      do_reset();
      step_y(2'd1, 117);
      checks++; if ({ball_y, ball_too_high} !== {10'd2, 1'b0}) begin errors++; $display("FAIL wall_y2 got y=%0d th=%b expected 2/0", ball_y, ball_too_high); end
      step_y(2'd1, 1);
      checks++; if ({ball_y, ball_too_high, y_sign} !== {10'd0, 1'b1, 1'b1}) begin errors++; $display("FAIL wall_top got y=%0d th=%b ys=%b expected 0/1/1", ball_y, ball_too_high, y_sign); end
      step_y(2'd1, 1);
      checks++; if (ball_y !== 10'd0) begin errors++; $display("FAIL wall_top_sat got %0d expected 0", ball_y); end
      step_y(2'd2, 235);
      checks++; if ({ball_y, ball_too_low} !== {10'd470, 1'b0}) begin errors++; $display("FAIL wall_y470 got y=%0d tl=%b expected 470/0", ball_y, ball_too_low); end
      step_y(2'd2, 1);
      checks++; if ({ball_y, ball_too_low, y_sign} !== {10'd472, 1'b1, 1'b0}) begin errors++; $display("FAIL wall_bot got y=%0d tl=%b ys=%b expected 472/1/0", ball_y, ball_too_low, y_sign); end
      step_y(2'd2, 1);
      checks++; if (ball_y !== 10'd472) begin errors++; $display("FAIL wall_bot_sat got %0d expected 472", ball_y); end
      step_y(2'd0, 1);
      checks++; if ({ball_y, y_sign} !== {10'd236, 1'b0}) begin errors++; $display("FAIL y_centre got y=%0d ys=%b expected 236/0", ball_y, y_sign); end
   endtask

   task automatic test_ai_collision();
      do_reset();
      step_y(2'd2, 2);
      step_x(2'd1, 145);
      checks++; if ({ball_x, ai_collision} !== {10'd606, 1'b0}) begin errors++; $display("FAIL aic_606 got x=%0d c=%b expected 606/0", ball_x, ai_collision); end
      step_x(2'd1, 1);
      checks++; if ({ball_x, ai_collision, player_scored} !== {10'd608, 1'b1, 1'b0}) begin errors++; $display("FAIL aic_608 got x=%0d c=%b ps=%b expected 608/1/0", ball_x, ai_collision, player_scored); end
      step_x(2'd2, 1);
      checks++; if ({ball_x, x_sign, ai_collision} !== {10'd606, 1'b0, 1'b0}) begin errors++; $display("FAIL aic_bounce got x=%0d s=%b c=%b expected 606/0/0", ball_x, x_sign, ai_collision); end
   endtask

   task automatic test_player_collision();
      do_reset();
      step_x(2'd2, 145);
      checks++; if ({ball_x, player_collision} !== {10'd26, 1'b0}) begin errors++; $display("FAIL pc_26 got x=%0d c=%b expected 26/0", ball_x, player_collision); end
      step_x(2'd2, 1);
      checks++; if ({ball_x, player_collision, ai_scored} !== {10'd24, 1'b1, 1'b0}) begin errors++; $display("FAIL pc_24 got x=%0d c=%b as=%b expected 24/1/0", ball_x, player_collision, ai_scored); end
      step_x(2'd2, 8);
      checks++; if ({ball_x, player_collision} !== {10'd8, 1'b0}) begin errors++; $display("FAIL pc_8 got x=%0d c=%b expected 8/0", ball_x, player_collision); end
      step_x(2'd2, 3);
      checks++; if ({ball_x, ai_scored} !== {10'd2, 1'b0}) begin errors++; $display("FAIL as_2 got x=%0d as=%b expected 2/0", ball_x, ai_scored); end
      step_x(2'd2, 1);
      checks++; if ({ball_x, ai_scored} !== {10'd0, 1'b1}) begin errors++; $display("FAIL as_0 got x=%0d as=%b expected 0/1", ball_x, ai_scored); end
      step_x(2'd2, 1);
      checks++; if (ball_x !== 10'd0) begin errors++; $display("FAIL x_sat0 got %0d expected 0", ball_x); end
   endtask

   task automatic test_scoring();
      do_reset();
      step_ai(3'd3, 1);
      checks++; if ({ai_y, ai_too_high} !== {10'd0, 1'b1}) begin errors++; $display("FAIL ai_top got y=%0d th=%b expected 0/1", ai_y, ai_too_high); end
      step_y(2'd2, 82);
      step_x(2'd1, 157);
      checks++; if ({ball_x, player_scored} !== {10'd630, 1'b0}) begin errors++; $display("FAIL ps_630 got x=%0d ps=%b expected 630/0", ball_x, player_scored); end
      step_x(2'd1, 1);
      checks++; if ({ball_y, ball_x, player_scored, ai_collision} !== {10'd400, 10'd632, 1'b1, 1'b0}) begin errors++; $display("FAIL ps_632 got y=%0d x=%0d ps=%b c=%b expected 400/632/1/0", ball_y, ball_x, player_scored, ai_collision); end
      sel_player_score = 1; en_player_score = 1;
      repeat (6) tick();
      checks++; if ({player_score, game_over} !== {4'd6, 1'b0}) begin errors++; $display("FAIL score6 got %0d go=%b expected 6/0", player_score, game_over); end
      tick();
      checks++; if ({player_score, game_over} !== {4'd7, 1'b1}) begin errors++; $display("FAIL score7 got %0d go=%b expected 7/1", player_score, game_over); end
      sel_player_score = 0;
      tick();
      en_player_score = 0;
      checks++; if ({player_score, game_over} !== {4'd0, 1'b0}) begin errors++; $display("FAIL score_clr got %0d go=%b expected 0/0", player_score, game_over); end
      sel_ai_score = 1; en_ai_score = 1;
      repeat (16) tick();
      checks++; if ({ai_score, game_over} !== {4'd15, 1'b1}) begin errors++; $display("FAIL ai_score15 got %0d go=%b expected 15/1", ai_score, game_over); end
      tick();
      en_ai_score = 0;
      checks++; if (ai_score !== 4'd15) begin errors++; $display("FAIL ai_score_sat got %0d expected 15", ai_score); end
   endtask

   task automatic test_paddle_clamp();
      do_reset();
      step_pad(3'd1, 51);
      checks++; if ({paddle_y, paddle_too_high} !== {10'd4, 1'b0}) begin errors++; $display("FAIL pad_4 got y=%0d th=%b expected 4/0", paddle_y, paddle_too_high); end
      step_pad(3'd1, 1);
      checks++; if ({paddle_y, paddle_too_high} !== {10'd0, 1'b1}) begin errors++; $display("FAIL pad_0 got y=%0d th=%b expected 0/1", paddle_y, paddle_too_high); end
      step_pad(3'd1, 1);
      checks++; if (paddle_y !== 10'd0) begin errors++; $display("FAIL pad_sat0 got %0d expected 0", paddle_y); end
      step_pad(3'd4, 1);
      checks++; if ({paddle_y, paddle_too_low} !== {10'd416, 1'b1}) begin errors++; $display("FAIL pad_bot got y=%0d tl=%b expected 416/1", paddle_y, paddle_too_low); end
      step_pad(3'd1, 1);
      checks++; if ({paddle_y, paddle_too_low} !== {10'd412, 1'b0}) begin errors++; $display("FAIL pad_412 got y=%0d tl=%b expected 412/0", paddle_y, paddle_too_low); end
      step_pad(3'd2, 2);
      checks++; if (paddle_y !== 10'd416) begin errors++; $display("FAIL pad_sat416 got %0d expected 416", paddle_y); end
      step_pad(3'd6, 3);
      checks++; if (paddle_y !== 10'd416) begin errors++; $display("FAIL pad_hold got %0d expected 416", paddle_y); end
      step_pad(3'd3, 1);
      checks++; if (paddle_y !== 10'd0) begin errors++; $display("FAIL pad_clamp0 got %0d expected 0", paddle_y); end
      step_pad(3'd0, 1);
      checks++; if (paddle_y !== 10'd208) begin errors++; $display("FAIL pad_centre got %0d expected 208", paddle_y); end
      step_ai(3'd4, 1);
      checks++; if ({ai_y, ai_too_low} !== {10'd416, 1'b1}) begin errors++; $display("FAIL ai_bot got y=%0d tl=%b expected 416/1", ai_y, ai_too_low); end
   endtask

   task automatic test_ai_tracking();
      do_reset();
      step_y(2'd1, 2);
      checks++; if ({ai_up, ai_down} !== 2'b00) begin errors++; $display("FAIL trk_232 got %b%b expected 00", ai_up, ai_down); end
      step_y(2'd1, 1);
      checks++; if ({ai_up, ai_down} !== 2'b10) begin errors++; $display("FAIL trk_230 got %b%b expected 10", ai_up, ai_down); end
      step_y(2'd1, 65);
      checks++; if ({ball_y, ai_up, ai_down} !== {10'd100, 2'b10}) begin errors++; $display("FAIL trk_100 got y=%0d %b%b expected 100/10", ball_y, ai_up, ai_down); end
      step_y(2'd2, 70);
      checks++; if ({ball_y, ai_up, ai_down} !== {10'd240, 2'b00}) begin errors++; $display("FAIL trk_240 got y=%0d %b%b expected 240/00", ball_y, ai_up, ai_down); end
      step_y(2'd2, 1);
      checks++; if ({ai_up, ai_down} !== 2'b01) begin errors++; $display("FAIL trk_242 got %b%b expected 01", ai_up, ai_down); end
   endtask

   task automatic test_back_to_back();
      do_reset();
      sel_x_ball = 2'd1; en_x_ball = 1;
      sel_y_ball = 2'd1; en_y_ball = 1;
      sel_y_paddle = 3'd2; en_y_paddle = 1;
      sel_y_ai = 3'd1; en_y_ai = 1;
      sel_player_score = 1; en_player_score = 1;
      sel_ai_score = 1; en_ai_score = 1;
      tick();
      idle_cmds();
      checks++; if ({ball_x, ball_y} !== {10'd318, 10'd234}) begin errors++; $display("FAIL all6_ball got %0d,%0d expected 318,234", ball_x, ball_y); end
      checks++; if ({paddle_y, ai_y} !== {10'd212, 10'd204}) begin errors++; $display("FAIL all6_pads got %0d,%0d expected 212,204", paddle_y, ai_y); end
      checks++; if ({player_score, ai_score, y_sign} !== {4'd1, 4'd1, 1'b1}) begin errors++; $display("FAIL all6_scores got %0d,%0d ys=%b expected 1,1,1", player_score, ai_score, y_sign); end
   endtask

   task automatic test_mid_reset();
      do_reset();
      step_x(2'd2, 3);
      sel_player_score = 1; en_player_score = 1;
      repeat (2) tick();
      en_player_score = 0;
      checks++; if ({ball_x, x_sign, player_score} !== {10'd310, 1'b0, 4'd2}) begin errors++; $display("FAIL pre_rst got x=%0d s=%b sc=%0d expected 310/0/2", ball_x, x_sign, player_score); end
      reset = 1;
      sel_x_ball = 2'd2; en_x_ball = 1;
      en_player_score = 1;
      tick();
      reset = 0;
      idle_cmds();
      checks++; if ({ball_x, x_sign, player_score} !== {10'd316, 1'b1, 4'd0}) begin errors++; $display("FAIL mid_rst got x=%0d s=%b sc=%0d expected 316/1/0", ball_x, x_sign, player_score); end
   endtask

   initial begin
      reset = 1;
      idle_cmds();
      test_reset();
      test_walls();
      test_ai_collision();
      test_player_collision();
      test_scoring();
      test_paddle_clamp();
      test_ai_tracking();
      test_back_to_back();
      test_mid_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
